// File: rtl/nonce_collector.sv
// nonce_collector: tracks the block base nonce, serialises processor hits into a result FIFO.
// Define NONCE_COLLECTOR_STATS_EN to add the saturating pushed-nonce counter hit_count_o.
module nonce_collector #(
    parameter int NUMPROCESSORS = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic                     newblock_i,
    input  logic [NUMPROCESSORS-1:0] success_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [31:0]              nonce_o,
    output logic                     overflow_o,
`ifdef NONCE_COLLECTOR_STATS_EN
    output logic [15:0]              hit_count_o,
`endif
    output logic                     busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (NUMPROCESSORS > 1) ? $clog2(NUMPROCESSORS) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              base_q, base_d, base_cap_q, base_cap_d;
    logic [NUMPROCESSORS-1:0] pending_q, pending_d, pending_rest;
    logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [31:0]              mem_q [FIFO_DEPTH];
    logic [IW-1:0]            idx;
    logic                     newblock, hit, empty, full, pop, push;

    assign newblock     = valid_i & newblock_i;
    assign hit          = valid_i & ~newblock_i & (|success_i);
    assign empty        = cnt_q == '0;
    assign full         = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign pop          = ~empty & ready_i & ~newblock;
    assign push         = (state_q == SCAN) & (~full | pop) & ~newblock;
    assign pending_rest = pending_q & (pending_q - NUMPROCESSORS'(1));

    always_comb begin
        idx = '0;
        for (int i = NUMPROCESSORS - 1; i >= 0; i--)
            if (pending_q[i]) idx = IW'(i);
    end

    always_comb begin
        base_d     = valid_i ? base_q + 32'(NUMPROCESSORS) : base_q;
        state_d    = state_q;
        pending_d  = pending_q;
        base_cap_d = base_cap_q;
        wr_d       = wr_q + AW'(push);
        rd_d       = rd_q + AW'(pop);
        cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d      = ovf_q | (hit & (state_q == SCAN));
        if (state_q == IDLE && hit) begin
            state_d    = SCAN;
            pending_d  = success_i;
            base_cap_d = base_q;
        end
        // Clearing the last pending bit returns to IDLE on the same edge as its push.
        if (push) begin
            pending_d = pending_rest;
            state_d   = (pending_rest == '0) ? IDLE : SCAN;
        end
        if (newblock) begin
            base_d    = '0;
            state_d   = IDLE;
            pending_d = '0;
            wr_d      = '0;
            rd_d      = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            base_cap_q <= '0;
            pending_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            base_cap_q <= base_cap_d;
            pending_q  <= pending_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= base_cap_q + 32'(idx);

    assign valid_o    = ~empty;
    assign nonce_o    = empty ? '0 : mem_q[rd_q];
    assign overflow_o = ovf_q;
    assign busy_o     = state_q == SCAN;

`ifdef NONCE_COLLECTOR_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;

    always_comb
        hit_count_d = newblock ? '0 : hit_count_q + 16'(push && hit_count_q != 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst) hit_count_q <= '0;
        else hit_count_q <= hit_count_d;
    end

    assign hit_count_o = hit_count_q;
`endif
endmodule

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector: directed checks of hit serialisation, backpressure, overflow, wrap and reset.
module tb_nonce_collector;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst, valid_i, newblock_i, ready_i;
    logic [N-1:0] success_i;
    logic         valid_o, overflow_o, busy_o;
    logic [31:0]  nonce_o;
    int           checks = 0;
    int           errors = 0;
`ifdef NONCE_COLLECTOR_STATS_EN
    logic [15:0]  hit_count_o;
`endif

    always #5 clk = ~clk;

    nonce_collector #(.NUMPROCESSORS(N), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .newblock_i (newblock_i),
        .success_i  (success_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .nonce_o    (nonce_o),
        .overflow_o (overflow_o),
`ifdef NONCE_COLLECTOR_STATS_EN
        .hit_count_o(hit_count_o),
`endif
        .busy_o     (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic v, input logic [31:0] n, input logic b);
        chk({tag, "_valid"}, 32'(valid_o), 32'(v));
        chk({tag, "_nonce"}, nonce_o, n);
        chk({tag, "_busy"}, 32'(busy_o), 32'(b));
    endtask

    task automatic drive(input logic v, input logic nb, input logic [N-1:0] s);
        valid_i    = v;
        newblock_i = nb;
        success_i  = s;
    endtask

    task automatic new_block();
        drive(1'b1, 1'b1, '0);
        tick();
        drive(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst     = 1'b1;
        ready_i = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        st("reset", 1'b0, 0, 1'b0);
        chk("reset_ovf", 32'(overflow_o), 0);
`ifdef NONCE_COLLECTOR_STATS_EN
        chk("reset_stats", 32'(hit_count_o), 0);
`endif
        // Single hit on bit 5 at base 30.
        ready_i = 1'b1;
        new_block();
        drive(1'b1, 1'b0, '0);
        repeat (3) tick();
        drive(1'b1, 1'b0, 10'b0000100000);
        tick();
        drive(1'b0, 1'b0, '0);
        st("single_cap", 1'b0, 0, 1'b1);
        tick();
        st("single_out", 1'b1, 35, 1'b0);
        tick();
        st("single_done", 1'b0, 0, 1'b0);
`ifdef NONCE_COLLECTOR_STATS_EN
        chk("stats_single", 32'(hit_count_o), 1);
`endif
        // Bits 9,2,0 at base 0 come out lowest index first.
        new_block();
        drive(1'b1, 1'b0, 10'b1000000101);
        tick();
        drive(1'b0, 1'b0, '0);
        st("multi_cap", 1'b0, 0, 1'b1);
        tick();
        st("multi_0", 1'b1, 0, 1'b1);
        tick();
        st("multi_2", 1'b1, 2, 1'b1);
        tick();
        st("multi_9", 1'b1, 9, 1'b0);
        tick();
        st("multi_done", 1'b0, 0, 1'b0);
        // Six hits at base 100 against a stalled four-entry FIFO.
        new_block();
        ready_i = 1'b0;
        drive(1'b1, 1'b0, '0);
        repeat (10) tick();
        drive(1'b1, 1'b0, 10'b0111011010);
        tick();
        drive(1'b0, 1'b0, '0);
        repeat (5) tick();
        st("bp_full", 1'b1, 101, 1'b1);
        ready_i = 1'b1;
        tick();
        st("bp_103", 1'b1, 103, 1'b1);
        tick();
        st("bp_104", 1'b1, 104, 1'b0);
        tick();
        st("bp_106", 1'b1, 106, 1'b0);
        tick();
        st("bp_107", 1'b1, 107, 1'b0);
        tick();
        st("bp_108", 1'b1, 108, 1'b0);
        tick();
        st("bp_empty", 1'b0, 0, 1'b0);
        chk("bp_ovf", 32'(overflow_o), 0);
        // Second hit vector during SCAN is dropped.
        new_block();
        ready_i = 1'b0;
        drive(1'b1, 1'b0, 10'h3FF);
        tick();
        drive(1'b1, 1'b0, 10'h001);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("ovf_set", 32'(overflow_o), 1);
        repeat (4) tick();
        st("ovf_full", 1'b1, 0, 1'b1);
        ready_i = 1'b1;
        for (int k = 1; k < 10; k++) begin
            tick();
            st("ovf_drain", 1'b1, k, k <= 5);
        end
        tick();
        st("ovf_empty", 1'b0, 0, 1'b0);
        chk("ovf_sticky", 32'(overflow_o), 1);
        // Newblock flushes a non-empty FIFO, clears overflow and ignores its success_i.
        ready_i = 1'b0;
        drive(1'b1, 1'b0, 10'h001);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        st("nb_pre", 1'b1, 20, 1'b0);
        ready_i = 1'b1;
        drive(1'b1, 1'b1, 10'h3FF);
        tick();
        drive(1'b0, 1'b0, '0);
        st("nb_flush", 1'b0, 0, 1'b0);
        chk("nb_ovf", 32'(overflow_o), 0);
        tick();
        st("nb_idle", 1'b0, 0, 1'b0);
        // Nonce wraps modulo 2^32 from a preloaded base.
        force dut.base_q = 32'hFFFFFFFC;
        drive(1'b1, 1'b0, 10'b0000100000);
        tick();
        release dut.base_q;
        drive(1'b0, 1'b0, '0);
        st("wrap_cap", 1'b0, 0, 1'b1);
        tick();
        st("wrap", 1'b1, 1, 1'b0);
        tick();
        st("wrap_done", 1'b0, 0, 1'b0);
        // Reset with three hits pending and two nonces buffered.
        new_block();
        ready_i = 1'b0;
        drive(1'b1, 1'b0, 10'b0000011111);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        st("rst_pre", 1'b1, 0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        st("rst_mid", 1'b0, 0, 1'b0);
        chk("rst_ovf", 32'(overflow_o), 0);
        ready_i = 1'b1;
        new_block();
        drive(1'b1, 1'b0, 10'b0000000010);
        tick();
        drive(1'b0, 1'b0, '0);
        tick();
        st("rst_after", 1'b1, 1, 1'b0);
        tick();
        st("rst_done", 1'b0, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_collector.md
Name: nonce_collector

Overview:
Sits between the NUMPROCESSORS hash processors and the result/UART path.
- Tracks the per-block base nonce.
- Captures the per-processor success vector and serialises multiple hits into 32-bit nonces, lowest index first.
- Buffers the nonces in a small FIFO and hands them out over a valid/ready handshake.
- Flushes everything on a new block.

Parameters:
NUMPROCESSORS, 10, number of parallel hash processors; processor k tests nonce base+k each valid cycle.
FIFO_DEPTH, 4, number of result nonces buffered (power of 2, at least 2).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
valid_i  input  1  processor array output valid this cycle.
newblock_i  input  1  with valid_i, marks the start of a new block.
success_i  input  NUMPROCESSORS  per-processor hit flags; bit k is processor k.
ready_i  input  1  downstream accepts nonce_o.
valid_o  output  1  nonce_o holds a result.
nonce_o  output  32  winning nonce, valid when valid_o is high.
overflow_o  output  1  sticky: at least one hit was dropped since the last newblock or rst.
busy_o  output  1  high while the FSM is in SCAN.

Behaviour:
- Reset (rst=1 at an edge):
  - base=0, pending=0, state=IDLE, FIFO emptied, overflow_o=0.
  - Outputs after reset: valid_o=0, nonce_o=0, busy_o=0.
  - rst has priority over every other input, including mid-scan.
- Base counter (32-bit, wraps modulo 2^32):
  - valid_i & newblock_i: base<=0.
  - valid_i & ~newblock_i: the cycle's candidate nonces are base+k; base<=base+NUMPROCESSORS.
  - valid_i=0: base holds.
- Hit qualification: success_i is sampled only when valid_i & ~newblock_i. A hit cycle is a qualified cycle with success_i nonzero.
- FSM state IDLE:
  - On a hit cycle: pending<=success_i, base_cap<=current base (pre-increment), go to SCAN.
- FSM state SCAN:
  - k = index of the lowest set bit of pending.
  - Push condition: FIFO not full, or a pop occurs this cycle.
  - If the push condition holds: push (base_cap+k) mod 2^32 and clear bit k.
  - Otherwise stall; pending and base_cap hold.
  - When the push clears the last set bit, go to IDLE on the same edge.
  - A new hit cycle cannot be captured on that same edge; capture resumes the next cycle.
- Drops:
  - A hit cycle arriving while in SCAN is dropped and overflow_o<=1.
  - A hit cycle arriving while the FIFO is full is not dropped by itself; it is captured if the FSM is in IDLE.
- Latency:
  - Hit at edge t: captured at edge t.
  - First nonce pushed at edge t+1; valid_o=1 in the cycle after edge t+1.
  - m hits in one cycle take m push cycles with no backpressure.
- FIFO and output:
  - valid_o = FIFO not empty; nonce_o = head entry, or 0 when empty.
  - Pop when valid_o & ready_i.
  - Simultaneous push and pop: occupancy is unchanged; order is preserved.
  - Pop on empty is ignored.
- Newblock (valid_i & newblock_i):
  - Same edge: FIFO flushed, pending<=0, state<=IDLE, overflow_o<=0, base<=0.
  - Any push or pop in that cycle is discarded.
  - success_i in that cycle is ignored.

Optional Feature:
NONCE_COLLECTOR_STATS_EN
- Defined: adds output hit_count_o [15:0].
  - Counts every nonce pushed into the FIFO and saturates at 16'hFFFF.
  - Cleared by rst and by newblock; reset value 0.
  - Dropped hits are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single hit: rst, newblock, 3 valid cycles, then success_i=10'b0000100000 on the 4th, ready_i=1 -> valid_o 2 cycles later with nonce_o=35 (base 30+5); one beat only.
- Multi-hit ordering: success_i=bits {9,2,0} at base 0, ready_i=1 -> nonces 0, 2, 9 on consecutive cycles; busy_o high 3 cycles.
- Backpressure/full: ready_i=0, FIFO_DEPTH=4, 6 bits set at base 100 -> 4 entries held, busy_o stays 1; raise ready_i -> all 6 nonces in ascending order, none lost, overflow_o=0.
- Overflow: hit on 10 bits with ready_i=0, second hit the next valid cycle -> overflow_o=1, second vector's nonces never appear; newblock -> overflow_o=0, valid_o=0.
- Wrap: force base to 32'hFFFFFFFC via 4294967292/NUMPROCESSORS-scaled preload (or a NUMPROCESSORS=4 build), hit bit 5 (NUMPROCESSORS≥6) -> nonce_o=32'h00000001.
- Reset mid-scan: rst asserted while 3 hits pending and 2 in FIFO -> next cycle valid_o=0, busy_o=0; a subsequent newblock plus hit on bit 1 -> nonce_o=1.
